// File: rtl/ir_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_tx_pkg
// Purpose  : shared types, register map and car timing table for ir_tx_multicar
// Revision : 1.0
// ============================================================================
package ir_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_GAP    = 3'd2,
        ST_CARSEL = 3'd3,
        ST_BIT    = 3'd4
    } state_t;

    localparam logic [1:0] C_OFF_CMD    = 2'd0;
    localparam logic [1:0] C_OFF_CAR    = 2'd1;
    localparam logic [1:0] C_OFF_CTRL   = 2'd2;
    localparam logic [1:0] C_OFF_STATUS = 2'd3;

    // Burst lengths are in carrier periods; mark/space are the 1/0 bit lengths.
    typedef struct packed {
        logic [7:0]  start;
        logic [7:0]  carsel;
        logic [7:0]  gap;
        logic [7:0]  mark;
        logic [7:0]  space;
        logic [10:0] period;
    } timing_t;

    typedef timing_t [3:0] timing_table_t;

    // Listed from entry 3 down to entry 0.
    localparam timing_table_t C_TIMING_TABLE = '{
        '{8'd88,  8'd44, 8'd40, 8'd44, 8'd22, 11'd1334},  // green
        '{8'd192, 8'd24, 8'd24, 8'd48, 8'd24, 11'd1389},  // red
        '{8'd191, 8'd47, 8'd25, 8'd47, 8'd22, 11'd1389},  // blue
        '{8'd88,  8'd22, 8'd40, 8'd44, 8'd22, 11'd1250}   // yellow
    };

    function automatic logic carrier_high(input logic [10:0] cnt, input logic [10:0] period);
        return cnt < (period >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_packet_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ir_packet_fsm
// Purpose  : shared IR packet sequencer driven by a runtime timing row
// Revision : 1.0
// ============================================================================
module ir_packet_fsm
    import ir_tx_pkg::*;
#(
    parameter int CMD_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,      // synchronous, active-low
    input  logic                i_start,
    input  timing_t             i_row,
    input  logic [CMD_BITS-1:0] i_cmd,
    output logic                o_ir_led,
    output logic                o_busy
);

    localparam int               C_SEG_W    = $clog2(CMD_BITS + 3);
    localparam logic [C_SEG_W-1:0] C_SEG_LAST = C_SEG_W'(CMD_BITS + 2);

    state_t                r_state_q, w_state_d;
    timing_t               r_row_q, w_row_d;
    logic [CMD_BITS-1:0]   r_cmd_q, w_cmd_d;
    logic [C_SEG_W-1:0]    r_seg_q, w_seg_d;
    logic [10:0]           r_car_cnt_q, w_car_cnt_d;
    logic [7:0]            r_burst_q, w_burst_d;

    logic [7:0]            w_dur;
    logic                  w_period_end;
    logic                  w_burst_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_row_q     <= '0;
            r_cmd_q     <= '0;
            r_seg_q     <= '0;
            r_car_cnt_q <= '0;
            r_burst_q   <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_row_q     <= w_row_d;
            r_cmd_q     <= w_cmd_d;
            r_seg_q     <= w_seg_d;
            r_car_cnt_q <= w_car_cnt_d;
            r_burst_q   <= w_burst_d;
        end
    end

    // The command is shifted right after each bit, so bit 0 is always current.
    always_comb begin
        w_dur = r_row_q.gap;
        case (r_state_q)
            ST_START:  w_dur = r_row_q.start;
            ST_CARSEL: w_dur = r_row_q.carsel;
            ST_BIT:    w_dur = r_cmd_q[0] ? r_row_q.mark : r_row_q.space;
            default:   w_dur = r_row_q.gap;
        endcase
    end

    assign w_period_end = (r_car_cnt_q == r_row_q.period - 11'd1);
    assign w_burst_end  = w_period_end && (r_burst_q == w_dur - 8'd1);

    always_comb begin
        w_state_d   = r_state_q;
        w_row_d     = r_row_q;
        w_cmd_d     = r_cmd_q;
        w_seg_d     = r_seg_q;
        w_car_cnt_d = r_car_cnt_q;
        w_burst_d   = r_burst_q;

        if (r_state_q == ST_IDLE) begin
            if (i_start) begin
                w_row_d     = i_row;
                w_cmd_d     = i_cmd;
                w_seg_d     = '0;
                w_car_cnt_d = '0;
                w_burst_d   = '0;
                w_state_d   = ST_START;
            end
        end else begin
            w_car_cnt_d = w_period_end ? 11'd0 : r_car_cnt_q + 11'd1;
            if (w_period_end) begin
                w_burst_d = r_burst_q + 8'd1;
            end
            if (w_burst_end) begin
                w_burst_d = '0;
                if (r_state_q == ST_GAP) begin
                    // r_seg_q counts completed bursts: 1 = START done, 2+ = bits
                    if (r_seg_q == C_SEG_LAST) begin
                        w_state_d = ST_IDLE;
                    end else if (r_seg_q == C_SEG_W'(1)) begin
                        w_state_d = ST_CARSEL;
                    end else begin
                        w_state_d = ST_BIT;
                    end
                end else begin
                    w_seg_d   = r_seg_q + C_SEG_W'(1);
                    w_state_d = ST_GAP;
                    if (r_state_q == ST_BIT) begin
                        w_cmd_d = r_cmd_q >> 1;
                    end
                end
            end
        end
    end

    assign o_busy   = (r_state_q != ST_IDLE);
    assign o_ir_led = carrier_high(r_car_cnt_q, r_row_q.period) &&
                      (r_state_q == ST_START || r_state_q == ST_CARSEL || r_state_q == ST_BIT);

endmodule
`default_nettype wire

// File: rtl/ir_tx_multicar.sv
`default_nettype none
// ============================================================================
// Module   : ir_tx_multicar
// Purpose  : bus-mapped multi-car IR transmitter (registers, tick, trigger)
// Revision : 1.0
// ============================================================================
module ir_tx_multicar
    import ir_tx_pkg::*;
#(
    parameter int            CLK_HZ    = 50_000_000,
    parameter logic [7:0]    BASE_ADDR = 8'h90,
    parameter int            NUM_CARS  = 4,
    parameter int            PACKET_HZ = 10,
    parameter int            CMD_BITS  = 4,
    parameter timing_table_t TIMING    = C_TIMING_TABLE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDRESS_IN,
    inout  wire  [7:0] DATA,
    input  logic       BUS_WE,
    output logic       IR_LED,
    output logic       BUSY
);

    localparam int                  C_TICK_N   = CLK_HZ / PACKET_HZ;
    localparam int                  C_TICK_W   = (C_TICK_N > 1) ? $clog2(C_TICK_N) : 1;
    localparam logic [C_TICK_W-1:0] C_TICK_MAX = C_TICK_W'(C_TICK_N - 1);

    logic [CMD_BITS-1:0] r_cmd_q, w_cmd_d;
    logic [1:0]          r_car_q, w_car_d;
    logic                r_en_q, w_en_d;
    logic                r_oneshot_q, w_oneshot_d;
    logic                r_err_q, w_err_d;
    logic [C_TICK_W-1:0] r_tick_q, w_tick_d;

    logic       w_in_win;
    logic [1:0] w_off;
    logic       w_wr;
    logic       w_rd_en;
    logic [7:0] w_rdata;
    logic       w_tick;
    logic       w_trigger;
    logic       w_car_ok;
    logic       w_accept;
    logic       w_busy;
    logic       w_ir_led;
    logic       w_unused_data;

    assign w_in_win = (ADDRESS_IN >= BASE_ADDR) &&
                      ({1'b0, ADDRESS_IN} < ({1'b0, BASE_ADDR} + 9'd4));
    assign w_off    = 2'(ADDRESS_IN - BASE_ADDR);
    assign w_wr     = BUS_WE && w_in_win;
    assign w_rd_en  = !BUS_WE && w_in_win;
    assign w_unused_data = ^DATA;

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            C_OFF_CMD:    w_rdata[CMD_BITS-1:0] = r_cmd_q;
            C_OFF_CAR:    w_rdata[1:0]          = r_car_q;
            C_OFF_CTRL:   w_rdata[0]            = r_en_q;
            C_OFF_STATUS: w_rdata[1:0]          = {r_err_q, w_busy};
            default:      w_rdata = 8'h00;
        endcase
    end

    assign DATA = w_rd_en ? w_rdata : 8'hzz;

    assign w_tick    = (r_tick_q == C_TICK_MAX);
    assign w_trigger = (w_tick && r_en_q) || r_oneshot_q;
    assign w_car_ok  = ({1'b0, r_car_q} < 3'(NUM_CARS));
    assign w_accept  = w_trigger && !w_busy && w_car_ok;

    always_comb begin
        w_cmd_d     = r_cmd_q;
        w_car_d     = r_car_q;
        w_en_d      = r_en_q;
        w_oneshot_d = 1'b0;
        w_err_d     = r_err_q;
        w_tick_d    = w_tick ? '0 : r_tick_q + C_TICK_W'(1);

        if (w_wr) begin
            case (w_off)
                C_OFF_CMD:  w_cmd_d = DATA[CMD_BITS-1:0];
                C_OFF_CAR:  w_car_d = DATA[1:0];
                C_OFF_CTRL: begin
                    w_en_d      = DATA[0];
                    w_oneshot_d = DATA[1];
                end
                default: ;
            endcase
        end

        // Triggers arriving while busy are dropped and leave ERR_SEL untouched.
        if (w_trigger && !w_busy) begin
            w_err_d = !w_car_ok;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cmd_q     <= '0;
            r_car_q     <= '0;
            r_en_q      <= 1'b0;
            r_oneshot_q <= 1'b0;
            r_err_q     <= 1'b0;
            r_tick_q    <= '0;
        end else begin
            r_cmd_q     <= w_cmd_d;
            r_car_q     <= w_car_d;
            r_en_q      <= w_en_d;
            r_oneshot_q <= w_oneshot_d;
            r_err_q     <= w_err_d;
            r_tick_q    <= w_tick_d;
        end
    end

    ir_packet_fsm #(
        .CMD_BITS (CMD_BITS)
    ) u_fsm (
        .clk      (CLK),
        .rst      (RST),
        .i_start  (w_accept),
        .i_row    (TIMING[r_car_q]),
        .i_cmd    (r_cmd_q),
        .o_ir_led (w_ir_led),
        .o_busy   (w_busy)
    );

    assign IR_LED = w_ir_led;
    assign BUSY   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ir_tx_multicar.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_tx_multicar
// Purpose  : scoreboard bench for ir_tx_multicar with a shortened timing table
// Revision : 1.0
// ============================================================================
module tb_ir_tx_multicar;
    import ir_tx_pkg::*;

    localparam logic [7:0] C_BASE = 8'h90;
    // start, carsel, gap, mark, space, period; entries 3 down to 0
    localparam timing_table_t C_TB_TABLE = '{
        '{8'd5, 8'd3, 8'd3, 8'd4, 8'd2, 11'd8},
        '{8'd9, 8'd2, 8'd2, 8'd4, 8'd2, 11'd6},
        '{8'd6, 8'd3, 8'd2, 8'd4, 8'd2, 11'd7},
        '{8'd8, 8'd2, 8'd4, 8'd4, 8'd2, 11'd10}
    };

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] ADDRESS_IN = 8'h00;
    logic       BUS_WE = 1'b0;
    wire  [7:0] DATA;
    wire        IR_LED;
    wire        BUSY;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_data = 8'h00;

    assign DATA = tb_drv ? tb_data : 8'hzz;

    always #5 CLK = ~CLK;

    ir_tx_multicar #(
        .CLK_HZ    (20_000),
        .BASE_ADDR (C_BASE),
        .NUM_CARS  (3),
        .PACKET_HZ (10),
        .CMD_BITS  (4),
        .TIMING    (C_TB_TABLE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADDRESS_IN (ADDRESS_IN),
        .DATA       (DATA),
        .BUS_WE     (BUS_WE),
        .IR_LED     (IR_LED),
        .BUSY       (BUSY)
    );

    typedef struct {
        int len;
        int first_hi;
        int edges;
        int gap;
    } pkt_t;

    pkt_t       pkt_q[$];
    logic [7:0] rd_q[$];
    string      rd_name_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       rd_active = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Read monitor: compares DATA mid-cycle while a read is on the bus.
    initial begin
        forever begin
            @(negedge CLK);
            if (rd_active) begin
                if (rd_q.size() == 0) begin
                    check("read_unexpected", 1, 0);
                end else begin
                    check(rd_name_q.pop_front(), int'(DATA), int'(rd_q.pop_front()));
                end
            end
        end
    end

    // Packet monitor: measures each BUSY window and compares on its fall.
    int   cyc = 0;
    int   prev_rise = -1;
    int   this_gap = -1;
    int   len = 0;
    int   hi_run = 0;
    int   edges = 0;
    bit   hi_seen = 1'b0;
    bit   hi_done = 1'b0;
    logic busy_prev = 1'b0;
    logic led_prev = 1'b0;
    pkt_t exp_pkt;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (BUSY && !busy_prev) begin
                this_gap  = (prev_rise < 0) ? -1 : cyc - prev_rise;
                prev_rise = cyc;
                len = 0; hi_run = 0; edges = 0;
                hi_seen = 1'b0; hi_done = 1'b0;
            end
            if (BUSY) begin
                len++;
                if (IR_LED && !led_prev) edges++;
                if (IR_LED && !hi_done) begin
                    hi_run++;
                    hi_seen = 1'b1;
                end else if (!IR_LED && hi_seen) begin
                    hi_done = 1'b1;
                end
            end
            if (!BUSY && busy_prev) begin
                if (pkt_q.size() == 0) begin
                    check("packet_unexpected", 1, 0);
                end else begin
                    exp_pkt = pkt_q.pop_front();
                    if (exp_pkt.len >= 0)   check("pkt_busy_len", len, exp_pkt.len);
                    check("pkt_first_high", hi_run, exp_pkt.first_hi);
                    if (exp_pkt.edges >= 0) check("pkt_led_bursts", edges, exp_pkt.edges);
                    if (exp_pkt.gap >= 0)   check("pkt_start_gap", this_gap, exp_pkt.gap);
                end
            end
            busy_prev = BUSY;
            led_prev  = IR_LED;
        end
    end

    task automatic wr(input logic [1:0] off, input logic [7:0] val);
        @(posedge CLK); #1;
        ADDRESS_IN = C_BASE + 8'(off);
        BUS_WE = 1'b1; tb_drv = 1'b1; tb_data = val;
        @(posedge CLK); #1;
        BUS_WE = 1'b0; tb_drv = 1'b0; ADDRESS_IN = 8'h00;
    endtask

    task automatic rd(input string name, input logic [1:0] off, input logic [7:0] exp);
        @(posedge CLK); #1;
        ADDRESS_IN = C_BASE + 8'(off);
        BUS_WE = 1'b0;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        rd_active = 1'b1;
        @(posedge CLK); #1;
        rd_active = 1'b0;
        ADDRESS_IN = 8'h00;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (BUSY !== lvl && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, int'(BUSY === lvl), 1);
    endtask

    initial begin
        // Bus writes (including ONESHOT) while held in reset must be ignored.
        wr(C_OFF_CMD, 8'h05);
        wr(C_OFF_CTRL, 8'h03);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ir_led", int'(IR_LED), 0);
        check("rst_busy", int'(BUSY), 0);
        rd("rst_cmd", C_OFF_CMD, 8'h00);
        rd("rst_car", C_OFF_CAR, 8'h00);
        rd("rst_ctrl", C_OFF_CTRL, 8'h00);
        rd("rst_status", C_OFF_STATUS, 8'h00);

        wr(C_OFF_CMD, 8'hFF);
        rd("cmd_masked", C_OFF_CMD, 8'h0F);
        wr(C_OFF_STATUS, 8'hFF);
        rd("status_ro", C_OFF_STATUS, 8'h00);

        // Yellow, CMD=F: (8+4+2+4+4*(4+4))*10 = 500 clocks, 26 carrier bursts.
        pkt_q.push_back('{500, 5, 26, -1});
        wr(C_OFF_CTRL, 8'h02);
        rd("ctrl_oneshot_reads0", C_OFF_CTRL, 8'h00);
        rd("status_busy", C_OFF_STATUS, 8'h01);
        wr(C_OFF_CAR, 8'h02);
        rd("car_readback", C_OFF_CAR, 8'h02);
        wait_busy(1'b0, 1000, "yellow_end");

        // Red, CMD=F: (9+2+2+2+4*(4+2))*6 = 234 clocks, 27 bursts.
        pkt_q.push_back('{234, 3, 27, -1});
        wr(C_OFF_CTRL, 8'h02);
        wait_busy(1'b1, 10, "red_f_start");
        wait_busy(1'b0, 400, "red_f_end");

        // Red, CMD=0, periodic: (9+2+2+2+4*(2+2))*6 = 186 clocks, rises 2000 apart.
        wr(C_OFF_CMD, 8'h00);
        pkt_q.push_back('{186, 3, 19, -1});
        pkt_q.push_back('{186, 3, 19, 2000});
        pkt_q.push_back('{186, 3, 19, 2000});
        wr(C_OFF_CTRL, 8'h01);
        for (int i = 0; i < 3; i++) begin
            wait_busy(1'b1, 2100, "periodic_start");
            if (i < 2) wait_busy(1'b0, 400, "periodic_end");
        end
        wr(C_OFF_CTRL, 8'h00);
        rd("ctrl_en_cleared", C_OFF_CTRL, 8'h00);
        wait_busy(1'b0, 400, "periodic_last_end");
        repeat (2500) @(posedge CLK);
        #1;

        // CAR_SEL beyond NUM_CARS: no packet, ERR_SEL set.
        wr(C_OFF_CAR, 8'h03);
        wr(C_OFF_CTRL, 8'h02);
        repeat (5) @(posedge CLK);
        #1;
        check("err_no_busy", int'(BUSY), 0);
        rd("status_err", C_OFF_STATUS, 8'h02);

        // Yellow, CMD=0: (8+4+2+4+4*(2+4))*10 = 420 clocks, 18 bursts; clears ERR.
        wr(C_OFF_CAR, 8'h00);
        pkt_q.push_back('{420, 5, 18, -1});
        wr(C_OFF_CTRL, 8'h02);
        rd("status_err_cleared", C_OFF_STATUS, 8'h01);
        wait_busy(1'b0, 600, "yellow0_end");
        rd("status_idle", C_OFF_STATUS, 8'h00);

        // Reset during BIT0 (packet clocks 180..219) of a yellow packet.
        wr(C_OFF_CMD, 8'h0F);
        pkt_q.push_back('{-1, 5, -1, -1});
        wr(C_OFF_CTRL, 8'h03);
        wait_busy(1'b1, 10, "abort_start");
        repeat (200) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_ir_led", int'(IR_LED), 0);
        check("abort_busy", int'(BUSY), 0);
        RST = 1'b1;
        repeat (2500) @(posedge CLK);
        #1;
        rd("abort_ctrl", C_OFF_CTRL, 8'h00);
        rd("abort_cmd", C_OFF_CMD, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        check("pkt_queue_drained", pkt_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
